// File: rtl/instruction_fetch_pkg.sv
// rtl/instruction_fetch_pkg.sv - shared instruction field map, opcode values and PC mux selects
package instruction_fetch_pkg;

    localparam int INSTR_W    = 28;
    localparam int ADDR_W     = 16;
    localparam int FIELD_W    = 8;

    localparam int OPCODE_LSB = 20;
    localparam int SRC0_LSB   = 16;
    localparam int SRC0_W     = 4;
    localparam int DEST_LSB   = 8;
    localparam int SRC1_LSB   = 0;
    localparam int IMM_LSB    = 0;
    localparam int IMM_W      = 16;

    localparam logic [7:0] OP_NOP = 8'h00;
    localparam logic [7:0] OP_STO = 8'h01;
    localparam logic [7:0] OP_ADD = 8'h02;
    localparam logic [7:0] OP_BLE = 8'h03;
    localparam logic [7:0] OP_JMP = 8'h04;
    localparam logic [7:0] OP_LED = 8'h05;

    localparam logic [7:0] REG_ZERO = 8'd0;
    localparam logic [7:0] REG_R1   = 8'd1;
    localparam logic [7:0] REG_R2   = 8'd2;
    localparam logic [7:0] REG_R3   = 8'd3;

    typedef enum logic [1:0] {
        PC_HOLD   = 2'd0,
        PC_INC    = 2'd1,
        PC_BRANCH = 2'd2,
        PC_JMP    = 2'd3
    } pc_sel_e;

endpackage

// File: rtl/instruction_fetch_pc.sv
// rtl/instruction_fetch_pc.sv - fetch_pc: program counter register and next-PC mux
module fetch_pc
    import instruction_fetch_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        Clock,
    input  logic        Reset_n,
    input  logic [1:0]  sel_i,
    input  logic [15:0] branch_target_i,
    input  logic [15:0] jmp_target_i,
    output logic [15:0] pc_o
);

    logic [15:0] pc_q;
    logic [15:0] pc_d;

    // Next PC: increment wraps naturally at 16 bits
    always_comb begin
        pc_d = pc_q;
        case (sel_i)
            PC_INC:    pc_d = pc_q + 16'd1;
            PC_BRANCH: pc_d = branch_target_i;
            PC_JMP:    pc_d = jmp_target_i;
            default:   pc_d = pc_q;
        endcase
    end

    // PC register
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - fetch stage with BOOT/RUN/FLUSH control; FETCH_JMP_EARLY_EN enables early JMP
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        Clock,
    input  logic        Reset_n,
    output logic [15:0] oAddress,
    input  logic [27:0] iInstruction,
    input  logic        iStall,
    input  logic        iBranchTaken,
    input  logic [15:0] iBranchTarget,
    output logic        oValid,
    output logic [27:0] oInstruction,
    output logic [15:0] oPC,
    output logic [7:0]  oOpcode,
    output logic [7:0]  oDest,
    output logic [7:0]  oSrc1,
    output logic [7:0]  oSrc0,
    output logic [15:0] oImm16
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    state_e      state_q;
    logic        valid_q;
    logic [27:0] instr_q;
    logic [15:0] opc_q;

    logic        redirect;
    logic        fetch;
    logic        early_jmp;
    logic [1:0]  pc_sel;
    logic [15:0] jmp_target;

    // BOOT ignores redirects; a redirect always wins over a stall
    assign redirect   = (state_q != ST_BOOT) && iBranchTaken;
    assign fetch      = (state_q != ST_BOOT) && !iBranchTaken && !iStall;
    assign jmp_target = {8'h00, iInstruction[DEST_LSB +: FIELD_W]};

`ifdef FETCH_JMP_EARLY_EN
    assign early_jmp = (iInstruction[OPCODE_LSB +: FIELD_W] == OP_JMP);
`else
    assign early_jmp = 1'b0;
`endif

    // Select the PC source; redirect has priority over an early JMP
    always_comb begin
        pc_sel = PC_HOLD;
        if (redirect) begin
            pc_sel = PC_BRANCH;
        end else if (fetch) begin
            pc_sel = early_jmp ? PC_JMP : PC_INC;
        end
    end

    fetch_pc #(
        .RESET_PC(RESET_PC)
    ) u_fetch_pc (
        .Clock           (Clock),
        .Reset_n         (Reset_n),
        .sel_i           (pc_sel),
        .branch_target_i (iBranchTarget),
        .jmp_target_i    (jmp_target),
        .pc_o            (oAddress)
    );

    // Control FSM with registered instruction/PC/valid outputs; FLUSH is the single bubble
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= ST_BOOT;
            valid_q <= 1'b0;
            instr_q <= '0;
            opc_q   <= '0;
        end else begin
            case (state_q)
                ST_BOOT: begin
                    state_q <= ST_RUN;
                end
                ST_RUN, ST_FLUSH: begin
                    if (redirect) begin
                        valid_q <= 1'b0;
                        state_q <= ST_FLUSH;
                    end else if (fetch) begin
                        instr_q <= iInstruction;
                        opc_q   <= oAddress;
                        valid_q <= 1'b1;
                        state_q <= ST_RUN;
                    end
                end
                default: begin
                    state_q <= ST_BOOT;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign oValid       = valid_q;
    assign oInstruction = instr_q;
    assign oPC          = opc_q;
    assign oOpcode      = instr_q[OPCODE_LSB +: FIELD_W];
    assign oDest        = instr_q[DEST_LSB +: FIELD_W];
    assign oSrc1        = instr_q[SRC1_LSB +: FIELD_W];
    assign oSrc0        = {{(FIELD_W - SRC0_W){1'b0}}, instr_q[SRC0_LSB +: SRC0_W]};
    assign oImm16       = instr_q[IMM_LSB +: IMM_W];

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - self-checking bench for instruction_fetch
module tb_instruction_fetch;
    import instruction_fetch_pkg::*;

`ifdef FETCH_JMP_EARLY_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic        Clock = 1'b0;
    always #5 Clock = ~Clock;

    logic        Reset_n;
    logic        iStall;
    logic        iBranchTaken;
    logic [15:0] iBranchTarget;

    logic [15:0] oAddress;
    logic [27:0] iInstruction;
    logic        oValid;
    logic [27:0] oInstruction;
    logic [15:0] oPC;
    logic [7:0]  oOpcode, oDest, oSrc1, oSrc0;
    logic [15:0] oImm16;

    logic [15:0] f_addr;
    logic [27:0] f_instr;
    logic        f_valid;
    logic [27:0] f_oinstr;
    logic [15:0] f_pc;
    logic [7:0]  f_op, f_dest, f_s1, f_s0;
    logic [15:0] f_imm;

    logic [27:0] rom [0:255];

    assign iInstruction = rom[oAddress[7:0]];
    assign f_instr      = rom[f_addr[7:0]];

    instruction_fetch dut (
        .Clock(Clock), .Reset_n(Reset_n), .oAddress(oAddress), .iInstruction(iInstruction),
        .iStall(iStall), .iBranchTaken(iBranchTaken), .iBranchTarget(iBranchTarget),
        .oValid(oValid), .oInstruction(oInstruction), .oPC(oPC), .oOpcode(oOpcode),
        .oDest(oDest), .oSrc1(oSrc1), .oSrc0(oSrc0), .oImm16(oImm16)
    );

    instruction_fetch #(.RESET_PC(16'hFFFF)) dut_ff (
        .Clock(Clock), .Reset_n(Reset_n), .oAddress(f_addr), .iInstruction(f_instr),
        .iStall(iStall), .iBranchTaken(iBranchTaken), .iBranchTarget(iBranchTarget),
        .oValid(f_valid), .oInstruction(f_oinstr), .oPC(f_pc), .oOpcode(f_op),
        .oDest(f_dest), .oSrc1(f_s1), .oSrc0(f_s0), .oImm16(f_imm)
    );

    int checks = 0;
    int passed = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference model: architectural view only (boot flag, PC, output registers)
    bit          m_boot;
    logic [15:0] m_pc;
    logic        m_valid;
    logic [27:0] m_instr;
    logic [15:0] m_opc;

    task automatic model_reset();
        m_boot = 1'b1; m_pc = 16'h0000; m_valid = 1'b0; m_instr = '0; m_opc = '0;
    endtask

    task automatic model_edge();
        logic [27:0] w;
        if (m_boot) begin
            m_boot = 1'b0;
        end else if (iBranchTaken) begin
            m_pc = iBranchTarget;
            m_valid = 1'b0;
        end else if (!iStall) begin
            w = rom[m_pc[7:0]];
            m_instr = w;
            m_opc = m_pc;
            m_valid = 1'b1;
            if (EARLY && w[27:20] == OP_JMP) m_pc = {8'h00, w[15:8]};
            else m_pc = m_pc + 16'd1;
        end
    endtask

    task automatic compare_model(input string name);
        check({name, "_regs"}, {3'b0, oAddress, oValid, oPC, oInstruction},
              {3'b0, m_pc, m_valid, m_opc, m_instr});
        check({name, "_fields"}, {16'b0, oOpcode, oDest, oSrc1, oSrc0, oImm16},
              {16'b0, m_instr[27:20], m_instr[15:8], m_instr[7:0], 4'h0, m_instr[19:16], m_instr[15:0]});
    endtask

    task automatic step();
        @(posedge Clock);
        @(negedge Clock);
    endtask

    typedef struct {
        logic        stall;
        logic        br;
        logic [15:0] tgt;
        logic [15:0] addr;
        logic        valid;
        logic [15:0] pc;
    } vec_t;

    vec_t tbl [20];

    function automatic vec_t mk(input logic s, input logic b, input logic [15:0] t,
                                input logic [15:0] a, input logic v, input logic [15:0] p);
        vec_t r;
        r.stall = s; r.br = b; r.tgt = t; r.addr = a; r.valid = v; r.pc = p;
        return r;
    endfunction

    logic [15:0] ff_seq [3];

    initial begin
        logic [7:0] op;
        Reset_n = 1'b0; iStall = 1'b0; iBranchTaken = 1'b0; iBranchTarget = 16'h0000;
        for (int i = 0; i < 256; i++) begin
            logic [7:0] ib;
            ib = 8'(i);
            rom[i] = {OP_ADD, ib[3:0], ib + 8'h40, ib};
        end
        rom[14] = {OP_JMP, 4'h0, 8'd2, 8'h00};

        tbl[0]  = mk(0, 1, 16'h0030, 16'h0000, 0, 16'h0000);
        tbl[1]  = mk(0, 0, 16'h0000, 16'h0001, 1, 16'h0000);
        tbl[2]  = mk(0, 0, 16'h0000, 16'h0002, 1, 16'h0001);
        tbl[3]  = mk(0, 0, 16'h0000, 16'h0003, 1, 16'h0002);
        tbl[4]  = mk(0, 0, 16'h0000, 16'h0004, 1, 16'h0003);
        tbl[5]  = mk(0, 0, 16'h0000, 16'h0005, 1, 16'h0004);
        tbl[6]  = mk(1, 0, 16'h0000, 16'h0005, 1, 16'h0004);
        tbl[7]  = mk(1, 0, 16'h0000, 16'h0005, 1, 16'h0004);
        tbl[8]  = mk(1, 0, 16'h0000, 16'h0005, 1, 16'h0004);
        tbl[9]  = mk(0, 0, 16'h0000, 16'h0006, 1, 16'h0005);
        tbl[10] = mk(0, 0, 16'h0000, 16'h0007, 1, 16'h0006);
        tbl[11] = mk(1, 1, 16'h0008, 16'h0008, 0, 16'h0000);
        tbl[12] = mk(0, 0, 16'h0000, 16'h0009, 1, 16'h0008);
        tbl[13] = mk(0, 0, 16'h0000, 16'h000A, 1, 16'h0009);
        tbl[14] = mk(0, 0, 16'h0000, 16'h000B, 1, 16'h000A);
        tbl[15] = mk(0, 0, 16'h0000, 16'h000C, 1, 16'h000B);
        tbl[16] = mk(0, 0, 16'h0000, 16'h000D, 1, 16'h000C);
        tbl[17] = mk(0, 0, 16'h0000, 16'h000E, 1, 16'h000D);
        tbl[18] = mk(0, 0, 16'h0000, EARLY ? 16'h0002 : 16'h000F, 1, 16'h000E);
        tbl[19] = mk(0, 0, 16'h0000, EARLY ? 16'h0003 : 16'h0010, 1, EARLY ? 16'h0002 : 16'h000F);
        ff_seq[0] = 16'hFFFF; ff_seq[1] = 16'h0000; ff_seq[2] = 16'h0001;

        // Reset state
        repeat (2) @(negedge Clock);
        check("rst_state", {3'b0, oAddress, oValid, oPC, oInstruction}, 64'h0);
        check("rst_ff_addr", 64'(f_addr), 64'h0000_0000_0000_FFFF);
        Reset_n = 1'b1;

        // Directed table: boot, streaming, 3-cycle stall, redirect under stall, JMP at 14
        for (int i = 0; i < 20; i++) begin
            iStall = tbl[i].stall; iBranchTaken = tbl[i].br; iBranchTarget = tbl[i].tgt;
            step();
            iBranchTaken = 1'b0;
            check($sformatf("tbl%0d_addr", i), 64'(oAddress), 64'(tbl[i].addr));
            check($sformatf("tbl%0d_valid", i), 64'(oValid), 64'(tbl[i].valid));
            if (tbl[i].valid) begin
                check($sformatf("tbl%0d_pc", i), 64'(oPC), 64'(tbl[i].pc));
                check($sformatf("tbl%0d_instr", i), 64'(oInstruction), 64'(rom[tbl[i].pc[7:0]]));
            end
            if (i < 3) check($sformatf("ff_addr%0d", i), 64'(f_addr), 64'(ff_seq[i]));
        end
        check("jmp_opcode", 64'(oOpcode), EARLY ? 64'(OP_ADD) : 64'(OP_ADD));
        check("jmp_prev_fields", {48'b0, oDest, oSrc1}, 64'({8'h4F, 8'h0F} - (EARLY ? 16'h0D0D : 16'h0)));

        // Async reset in the middle of FLUSH
        iBranchTaken = 1'b1; iBranchTarget = 16'h0020;
        step();
        iBranchTaken = 1'b0;
        check("flush_entered_valid", 64'(oValid), 64'h0);
        #1 Reset_n = 1'b0;
        #1;
        check("async_rst_clear", {3'b0, oAddress, oValid, oPC, oInstruction}, 64'h0);
        check("async_rst_ff_addr", 64'(f_addr), 64'h0000_0000_0000_FFFF);
        @(negedge Clock);
        Reset_n = 1'b1;
        step();
        check("post_rst_boot", {47'b0, oAddress, oValid}, 64'h0);
        step();
        check("post_rst_first", {31'b0, oAddress, oValid, oPC}, {31'b0, 16'h0001, 1'b1, 16'h0000});

        // Randomized run against the reference model
        @(negedge Clock);
        Reset_n = 1'b0;
        for (int i = 0; i < 256; i++) begin
            case ($urandom_range(0, 5))
                0: op = OP_NOP; 1: op = OP_STO; 2: op = OP_ADD;
                3: op = OP_BLE; 4: op = OP_JMP; default: op = OP_LED;
            endcase
            rom[i] = {op, 20'($urandom)};
        end
        model_reset();
        @(negedge Clock);
        Reset_n = 1'b1;
        compare_model("rnd_start");
        for (int c = 0; c < 500; c++) begin
            if ($urandom_range(0, 99) == 0) begin
                Reset_n = 1'b0;
                model_reset();
                #2;
                compare_model("rnd_async_rst");
                @(negedge Clock);
                Reset_n = 1'b1;
            end else begin
                iStall = ($urandom_range(0, 3) == 0);
                iBranchTaken = ($urandom_range(0, 7) == 0);
                iBranchTarget = ($urandom_range(0, 3) == 0) ? (16'hFFF8 + 16'($urandom_range(0, 7)))
                                                            : 16'($urandom_range(0, 255));
                @(posedge Clock);
                model_edge();
                @(negedge Clock);
                compare_model("rnd");
            end
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_PC, default 16'h0000, first fetch address after reset.
REQ-002 Clock  input  1  sole clock, all state updates on the rising edge.
REQ-003 Reset_n  input  1  asynchronous, active-low reset.
REQ-004 oAddress  output  16  program counter (PC) driven to the instruction ROM address input.
REQ-005 iInstruction  input  28  ROM data, combinational from oAddress, valid in the same cycle.
REQ-006 iStall  input  1  downstream hold request.
REQ-007 iBranchTaken  input  1  execute-stage redirect, one-cycle pulse.
REQ-008 iBranchTarget  input  16  redirect address, sampled when iBranchTaken=1.
REQ-009 oValid  output  1  oInstruction and decoded fields are a real instruction.
REQ-010 oInstruction  output  28  registered instruction word.
REQ-011 oPC  output  16  address oInstruction was fetched from.
REQ-012 oOpcode, oDest, oSrc1, oSrc0  outputs  8 each  bits [27:20], [15:8], [7:0] of oInstruction plus bits [19:16] zero-extended, per the shared field map; oImm16 output 16 = oInstruction[15:0].

Function
REQ-013 FSM states: BOOT, RUN, FLUSH.
REQ-014 BOOT: entered on reset; oValid=0; next edge goes to RUN with no PC change.
REQ-015 RUN, iStall=0, no redirect: oInstruction<=iInstruction, oPC<=oAddress, oValid<=1, PC<=PC+1.
REQ-016 RUN, iStall=1, no redirect: PC, oInstruction, oPC, oValid all hold.
REQ-017 iBranchTaken=1 in any state except BOOT: PC<=iBranchTarget, oValid<=0, state<=FLUSH; overrides iStall.
REQ-018 FLUSH: one bubble cycle with oValid=0; then RUN, fetching from the redirected PC.
REQ-019 Fetch-to-output latency: one clock; throughput one instruction per cycle without stalls or redirects.
REQ-020 PC increment wraps modulo 2^16: 16'hFFFF+1 = 16'h0000, no error flag.
REQ-021 iBranchTaken during BOOT is ignored.
REQ-022 Decoded field outputs are combinational from the oInstruction register, never from iInstruction.

Reset
REQ-023 Reset_n=0 asynchronously forces: PC=RESET_PC, state=BOOT, oValid=0, oInstruction=0, oPC=0.
REQ-024 Reset asserted mid-stall or mid-flush discards all pending state; no redirect survives reset.

Configuration
REQ-025 Macro FETCH_JMP_EARLY_EN defined: when RUN latches an instruction whose opcode is JMP, the same edge loads PC<={8'h00, iInstruction[15:8]}; that JMP is still emitted with oValid=1; no bubble.
REQ-026 FETCH_JMP_EARLY_EN undefined: JMP is treated like any other opcode, PC<=PC+1; execute must redirect through iBranchTaken.
REQ-027 When both apply, a simultaneous iBranchTaken takes priority over an early JMP.

Structure
REQ-028 Opcode constants (NOP, STO, ADD, BLE, JMP, LED, ...), register-index constants, field bit positions and widths, and the 28-bit instruction width live in the shared definitions header; the block defines no opcode values locally.
REQ-029 FSM state encodings are local to the module.
REQ-030 One sub-module, fetch_pc: holds the PC register and the next-PC mux (increment / hold / branch / early JMP).

Verification
REQ-031 Reset release, no stall, ROM holding distinct words at 0..3 -> oAddress 0,1,2,3 on consecutive cycles; oValid first high on the 2nd edge after release with oPC=0.
REQ-032 iStall=1 for 3 cycles at PC=5 -> oAddress stays 5, oInstruction/oPC hold for exactly 3 cycles, then resume at 6.
REQ-033 iBranchTaken pulse with iBranchTarget=16'h0008 while iStall=1 -> next oAddress=8, exactly one oValid=0 cycle, then oPC=8 valid.
REQ-034 FETCH_JMP_EARLY_EN defined, JMP with dest field 8'd2 at address 14 -> oAddress 15 never driven, next fetch at 2, JMP emitted with oValid=1. Same program without the macro -> fetch continues at 15.
REQ-035 RESET_PC=16'hFFFF, free-running -> oAddress sequence FFFF, 0000, 0001.
REQ-036 Reset_n pulled low asynchronously during FLUSH -> outputs clear immediately without a clock edge; after release, fetch restarts at RESET_PC via BOOT.
